// File: rtl/traffic_pkg.sv
// Shared lamp encodings, fault codes and direction indices for the traffic
// light controller and the conflict monitor that sits downstream of it.
package traffic_pkg;

    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    typedef enum logic [2:0] {
        FLT_NONE     = 3'd0,
        FLT_INVALID  = 3'd1,
        FLT_CONFLICT = 3'd2,
        FLT_ILLEGAL  = 3'd3,
        FLT_SHORT_G  = 3'd4,
        FLT_SHORT_Y  = 3'd5,
        FLT_WATCHDOG = 3'd6
    } fault_code_t;

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_S = 2'd1,
        DIR_E = 2'd2,
        DIR_W = 2'd3
    } dir_t;

    function automatic logic lamp_valid(input logic [2:0] code);
        return (code == LAMP_GRN) || (code == LAMP_YEL) || (code == LAMP_RED);
    endfunction

endpackage

// File: rtl/lamp_seq_checker.sv
// Per-direction sample/previous registers, dwell counter and colour-sequence
// checks for one approach of the intersection.
module lamp_seq_checker
    import traffic_pkg::*;
#(
    parameter int GREEN_MIN  = 8,
    parameter int YELLOW_MIN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] lamp_in,
    output logic [2:0] s,
    output logic       changed,
    output logic       invalid,
    output logic       illegal,
    output logic       short_g,
    output logic       short_y,
    output logic       non_red
);

    localparam int DWELL_SAT = (GREEN_MIN > YELLOW_MIN) ? GREEN_MIN : YELLOW_MIN;
    localparam int DWELL_W   = $clog2(DWELL_SAT + 1);

    logic [2:0]         p;
    logic [DWELL_W-1:0] dwell;

    // Dwell tracks the run length of the colour now held in p, so it is the
    // length of the phase that is just ending whenever s differs from p.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of s, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s     <= LAMP_RED;
            p     <= LAMP_RED;
            dwell <= '0;
        end else begin
            s <= lamp_in;
            p <= s;
            if (s != p) begin
                dwell <= DWELL_W'(1);
            end else if (dwell != DWELL_W'(DWELL_SAT)) begin
                dwell <= dwell + DWELL_W'(1);
            end
        end
    end

    assign changed = (s != p);
    assign invalid = !lamp_valid(s);
    assign non_red = (s != LAMP_RED);
    assign illegal = changed && !((p == LAMP_RED && s == LAMP_GRN) ||
                                  (p == LAMP_GRN && s == LAMP_YEL) ||
                                  (p == LAMP_YEL && s == LAMP_RED));
    assign short_g = (p == LAMP_GRN) && (s == LAMP_YEL) && (dwell < DWELL_W'(GREEN_MIN));
    assign short_y = (p == LAMP_YEL) && (s == LAMP_RED) && (dwell < DWELL_W'(YELLOW_MIN));

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Safety monitor between the traffic light controller and the lamp drivers:
// forwards clean patterns, latches the first fault and flashes red until reset.
module traffic_conflict_monitor
    import traffic_pkg::*;
#(
    parameter int GREEN_MIN  = 8,
    parameter int YELLOW_MIN = 4,
    parameter int MAX_DWELL  = 16,
    parameter int FLASH_HALF = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] north,
    input  logic [2:0] south,
    input  logic [2:0] east,
    input  logic [2:0] west,
    output logic [2:0] north_lamp,
    output logic [2:0] south_lamp,
    output logic [2:0] east_lamp,
    output logic [2:0] west_lamp,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [1:0] fault_dir
);

    localparam int STALL_W = $clog2(MAX_DWELL + 1);
    localparam int FLASH_W = $clog2(FLASH_HALF);

    logic [2:0] lamp_in [4];
    logic [2:0] samp    [4];
    logic       changed [4];
    logic       invalid [4];
    logic       illegal [4];
    logic       short_g [4];
    logic       short_y [4];
    logic       non_red [4];

    logic [STALL_W-1:0] stall_cnt, stall_next;
    logic [FLASH_W-1:0] flash_cnt;
    logic               flash_on;
    logic [2:0]         nonred_cnt;
    logic               any_change;
    fault_code_t        det_code;
    dir_t               det_dir;

    assign lamp_in[0] = north;
    assign lamp_in[1] = south;
    assign lamp_in[2] = east;
    assign lamp_in[3] = west;

    for (genvar i = 0; i < 4; i++) begin : g_dir
        lamp_seq_checker #(
            .GREEN_MIN  (GREEN_MIN),
            .YELLOW_MIN (YELLOW_MIN)
        ) u_chk (
            .clk     (clk),
            .rst     (rst),
            .lamp_in (lamp_in[i]),
            .s       (samp[i]),
            .changed (changed[i]),
            .invalid (invalid[i]),
            .illegal (illegal[i]),
            .short_g (short_g[i]),
            .short_y (short_y[i]),
            .non_red (non_red[i])
        );
    end

    // Checks are applied from lowest to highest priority, and each loop scans
    // directions from W down to N, so the last hit is the winning code/dir.
    // NOTE: every variable gets a default before any branch so no latch is
    // inferred; blocking assignments give the intended top-down override.
    always_comb begin
        nonred_cnt = '0;
        any_change = 1'b0;
        det_code   = FLT_NONE;
        det_dir    = DIR_N;
        for (int i = 0; i < 4; i++) begin
            nonred_cnt = nonred_cnt + {2'b00, non_red[i]};
            any_change = any_change | changed[i];
        end

        if (any_change) begin
            stall_next = '0;
        end else if (stall_cnt == STALL_W'(MAX_DWELL)) begin
            stall_next = stall_cnt;
        end else begin
            stall_next = stall_cnt + STALL_W'(1);
        end

        if (stall_next == STALL_W'(MAX_DWELL)) begin
            det_code = FLT_WATCHDOG;
        end
        for (int i = 3; i >= 0; i--) begin
            if (short_y[i]) begin det_code = FLT_SHORT_Y; det_dir = dir_t'(i[1:0]); end
        end
        for (int i = 3; i >= 0; i--) begin
            if (short_g[i]) begin det_code = FLT_SHORT_G; det_dir = dir_t'(i[1:0]); end
        end
        for (int i = 3; i >= 0; i--) begin
            if (illegal[i]) begin det_code = FLT_ILLEGAL; det_dir = dir_t'(i[1:0]); end
        end
        if (nonred_cnt > 3'd1) begin
            det_code = FLT_CONFLICT;
            for (int i = 3; i >= 0; i--) begin
                if (non_red[i]) det_dir = dir_t'(i[1:0]);
            end
        end
        for (int i = 3; i >= 0; i--) begin
            if (invalid[i]) begin det_code = FLT_INVALID; det_dir = dir_t'(i[1:0]); end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {north_lamp, south_lamp, east_lamp, west_lamp} <= {4{LAMP_RED}};
            fault      <= 1'b0;
            fault_code <= FLT_NONE;
            fault_dir  <= DIR_N;
            stall_cnt  <= '0;
            flash_cnt  <= '0;
            flash_on   <= 1'b0;
        end else begin
            stall_cnt <= stall_next;
            if (fault) begin
                // Sticky: code and direction stay frozen, only the flasher runs.
                if (flash_cnt == FLASH_W'(FLASH_HALF - 1)) begin
                    flash_cnt <= '0;
                    flash_on  <= !flash_on;
                    {north_lamp, south_lamp, east_lamp, west_lamp} <=
                        {4{flash_on ? LAMP_OFF : LAMP_RED}};
                end else begin
                    flash_cnt <= flash_cnt + FLASH_W'(1);
                end
            end else if (det_code != FLT_NONE) begin
                fault      <= 1'b1;
                fault_code <= det_code;
                fault_dir  <= det_dir;
                flash_cnt  <= '0;
                flash_on   <= 1'b1;
                {north_lamp, south_lamp, east_lamp, west_lamp} <= {4{LAMP_RED}};
            end else begin
                {north_lamp, south_lamp, east_lamp, west_lamp} <=
                    {samp[0], samp[1], samp[2], samp[3]};
            end
        end
    end

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Self-checking bench for traffic_conflict_monitor: nominal ring scoreboard,
// single-pattern fault table and hand-written multi-cycle fault sequences.
module tb_traffic_conflict_monitor;
    import traffic_pkg::*;

    localparam logic [11:0] ALL_RED = {4{LAMP_RED}};
    localparam logic [11:0] ALL_OFF = {4{LAMP_OFF}};

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] north, south, east, west;
    logic [2:0] north_lamp, south_lamp, east_lamp, west_lamp;
    logic       fault;
    logic [2:0] fault_code;
    logic [1:0] fault_dir;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    traffic_conflict_monitor dut (
        .clk        (clk),
        .rst        (rst),
        .north      (north),
        .south      (south),
        .east       (east),
        .west       (west),
        .north_lamp (north_lamp),
        .south_lamp (south_lamp),
        .east_lamp  (east_lamp),
        .west_lamp  (west_lamp),
        .fault      (fault),
        .fault_code (fault_code),
        .fault_dir  (fault_dir)
    );

    typedef struct packed {
        logic [11:0] pat;   // {north, south, east, west}
        logic [2:0]  code;  // 0 means the pattern is clean
        logic [1:0]  dir;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] pk(input logic [2:0] n, input logic [2:0] s,
                                       input logic [2:0] e, input logic [2:0] w);
        return {n, s, e, w};
    endfunction

    function automatic logic [11:0] lamps();
        return {north_lamp, south_lamp, east_lamp, west_lamp};
    endfunction

    // Controller's nominal ring: each direction green 8 then yellow 4, N->S->E->W.
    function automatic logic [11:0] nominal(input int c);
        logic [11:0] r;
        int d;
        r = ALL_RED;
        d = (c / 12) % 4;
        r[(3 - d) * 3 +: 3] = ((c % 12) < 8) ? LAMP_GRN : LAMP_YEL;
        return r;
    endfunction

    task automatic drive(input logic [11:0] pat);
        {north, south, east, west} = pat;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        drive(ALL_RED);
        tick();
        rst = 1'b0;
    endtask

    task automatic hold(input logic [11:0] pat, input int n);
        drive(pat);
        repeat (n) tick();
    endtask

    // Called right after the edge that samples the offending pattern.
    task automatic expect_fault(input string tag, input logic [2:0] code, input logic [1:0] dir);
        check($sformatf("%s quiet", tag), 12'(fault), 12'd0);
        tick();
        check($sformatf("%s fault", tag), 12'(fault), 12'd1);
        check($sformatf("%s code", tag), 12'(fault_code), 12'(code));
        check($sformatf("%s dir", tag), 12'(fault_dir), 12'(dir));
        check($sformatf("%s lamps", tag), lamps(), ALL_RED);
    endtask

    task automatic run_nominal(input int rings, input string tag);
        logic [11:0] exp_q [$];
        for (int c = 0; c < rings * 48; c++) begin
            drive(nominal(c));
            exp_q.push_back(nominal(c));
            tick();
            if (exp_q.size() == 2) begin
                check($sformatf("%s lamps c%0d", tag, c), lamps(), exp_q.pop_front());
            end
        end
        check($sformatf("%s no fault", tag), 12'(fault), 12'd0);
    endtask

    initial begin
        vecs[0] = '{pat: pk(LAMP_GRN, LAMP_RED, LAMP_GRN, LAMP_RED), code: 3'd2, dir: 2'd0};
        vecs[1] = '{pat: pk(LAMP_RED, 3'b011, LAMP_RED, LAMP_RED),   code: 3'd1, dir: 2'd1};
        vecs[2] = '{pat: pk(LAMP_YEL, LAMP_RED, LAMP_RED, LAMP_RED), code: 3'd3, dir: 2'd0};
        vecs[3] = '{pat: pk(LAMP_RED, LAMP_RED, LAMP_GRN, LAMP_YEL), code: 3'd2, dir: 2'd2};
        vecs[4] = '{pat: pk(LAMP_RED, LAMP_RED, 3'b000, LAMP_RED),   code: 3'd1, dir: 2'd2};
        vecs[5] = '{pat: pk(3'b011, LAMP_RED, LAMP_RED, 3'b111),     code: 3'd1, dir: 2'd0};
        vecs[6] = '{pat: pk(LAMP_RED, LAMP_GRN, LAMP_GRN, LAMP_GRN), code: 3'd2, dir: 2'd1};
        vecs[7] = '{pat: pk(LAMP_RED, LAMP_RED, LAMP_RED, LAMP_YEL), code: 3'd3, dir: 2'd3};
        vecs[8] = '{pat: pk(LAMP_RED, LAMP_RED, LAMP_RED, LAMP_GRN), code: 3'd0, dir: 2'd0};
        vecs[9] = '{pat: ALL_RED,                                    code: 3'd0, dir: 2'd0};

        // Reset values are visible while rst is still held.
        rst = 1'b1;
        drive(ALL_RED);
        #1;
        check("reset lamps", lamps(), ALL_RED);
        check("reset fault", 12'(fault), 12'd0);
        check("reset code", 12'(fault_code), 12'd0);
        check("reset dir", 12'(fault_dir), 12'd0);
        tick();
        rst = 1'b0;

        run_nominal(3, "nominal");

        // Single-pattern vectors, each from a fresh reset.
        for (int i = 0; i < 10; i++) begin
            apply_reset();
            drive(vecs[i].pat);
            tick();
            check($sformatf("v%0d early", i), 12'(fault), 12'd0);
            tick();
            check($sformatf("v%0d fault", i), 12'(fault), 12'(vecs[i].code != 3'd0));
            check($sformatf("v%0d code", i), 12'(fault_code), 12'(vecs[i].code));
            check($sformatf("v%0d dir", i), 12'(fault_dir), 12'(vecs[i].dir));
            check($sformatf("v%0d lamps", i), lamps(),
                  (vecs[i].code != 3'd0) ? ALL_RED : vecs[i].pat);
        end

        // Green held 8 then straight to red.
        apply_reset();
        hold(pk(LAMP_GRN, LAMP_RED, LAMP_RED, LAMP_RED), 8);
        hold(ALL_RED, 1);
        expect_fault("g_to_r", 3'd3, 2'd0);

        // South yellow only 2 samples.
        apply_reset();
        hold(pk(LAMP_RED, LAMP_GRN, LAMP_RED, LAMP_RED), 8);
        hold(pk(LAMP_RED, LAMP_YEL, LAMP_RED, LAMP_RED), 2);
        hold(ALL_RED, 1);
        expect_fault("short_y", 3'd5, 2'd1);

        // North green only 5 samples.
        apply_reset();
        hold(pk(LAMP_GRN, LAMP_RED, LAMP_RED, LAMP_RED), 5);
        hold(pk(LAMP_YEL, LAMP_RED, LAMP_RED, LAMP_RED), 1);
        expect_fault("short_g", 3'd4, 2'd0);

        // Watchdog: stall count is 0 after edge 2, reaching 16 at edge 18.
        begin
            int first;
            first = 0;
            apply_reset();
            drive(pk(LAMP_GRN, LAMP_RED, LAMP_RED, LAMP_RED));
            for (int k = 1; k <= 20; k++) begin
                tick();
                if (fault === 1'b1 && first == 0) first = k;
            end
            check("wd edge", 12'(first), 12'd18);
            check("wd code", 12'(fault_code), 12'd6);
            check("wd dir", 12'(fault_dir), 12'd0);
        end

        // Conflict, then the flash pattern; a later invalid code must not
        // overwrite the latched fault.
        apply_reset();
        hold(pk(LAMP_GRN, LAMP_RED, LAMP_GRN, LAMP_RED), 1);
        expect_fault("conflict", 3'd2, 2'd0);
        for (int k = 1; k < 16; k++) begin
            if (k == 4) drive(pk(3'b011, LAMP_RED, LAMP_RED, LAMP_RED));
            tick();
            check($sformatf("flash k%0d", k), lamps(), (((k / 4) % 2) == 0) ? ALL_RED : ALL_OFF);
        end
        check("sticky code", 12'(fault_code), 12'd2);
        check("sticky dir", 12'(fault_dir), 12'd0);

        // Asynchronous reset mid-flash, checked before the next clock edge.
        #2;
        rst = 1'b1;
        #1;
        check("async lamps", lamps(), ALL_RED);
        check("async fault", 12'(fault), 12'd0);
        check("async code", 12'(fault_code), 12'd0);
        check("async dir", 12'(fault_dir), 12'd0);
        tick();
        rst = 1'b0;
        run_nominal(1, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/traffic_conflict_monitor.md
# traffic_conflict_monitor

Safety stage directly downstream of the four-way traffic light controller. It samples the controller's north/south/east/west lamp codes and checks every cycle for invalid codes, conflicting greens, illegal colour transitions, short dwell and a stalled sequencer. Clean patterns are forwarded to the lamp drivers. On the first fault it latches a fault code and forces all lamps to flashing red until reset, so a faulty pattern never reaches the lamps.

## Interface
- GREEN_MIN, 8: minimum consecutive sampled cycles of green before green→yellow is legal
- YELLOW_MIN, 4: minimum consecutive sampled cycles of yellow before yellow→red is legal
- MAX_DWELL, 16: watchdog limit of consecutive unchanged samples
- FLASH_HALF, 4: cycles per on/off half-period of fault flashing
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- north, south, east, west  in  3 each  lamp codes from controller: 001 green, 010 yellow, 100 red
- north_lamp, south_lamp, east_lamp, west_lamp  out  3 each  registered lamp drive, same encoding; 000 = dark
- fault  out  1  latched fault flag
- fault_code  out  3  0 none, 1 invalid code, 2 conflict, 3 illegal transition, 4 short green, 5 short yellow, 6 watchdog
- fault_dir  out  2  offending direction: N=0, S=1, E=2, W=3

## Operation
- Stage 1: at each edge, s_dir <= input; p_dir <= s_dir (previous sample).
- Stage 2: checks run on s/p; results are registered.
- Reset: lamps 100, fault 0, fault_code 0, fault_dir 0. s/p are set to 100, and all counters are 0.
- Invalid: any s_dir not in {001,010,100}.
- Conflict: more than one s_dir ≠ 100. All-red is legal.
- Legal transitions per direction: red→green, green→yellow, yellow→red, or unchanged. Anything else is illegal.
- Dwell counter per direction: set to 1 when the colour changes; otherwise increments, saturating at max(GREEN_MIN, YELLOW_MIN).
- A green→yellow transition with green dwell < GREEN_MIN is a short green. A yellow→red transition with yellow dwell < YELLOW_MIN is a short yellow.
- Watchdog: stall counter is cleared when any s ≠ p and incremented otherwise. A fault is raised when it reaches MAX_DWELL.
- Priority when faults coincide: lowest code wins. Within a code, the lowest direction index wins. fault_dir is 0 for watchdog. For conflict, fault_dir is the lowest non-red index.
- Fault is sticky. Only rst clears it, and later faults do not overwrite the code or direction.
- Normal mode: lamp <= s when no fault is registered and none is detected this cycle.
- Fault mode: all four lamps show 100 for FLASH_HALF cycles, then 000 for FLASH_HALF cycles, repeating. The red phase starts on the edge that raises fault.

## Timing
- Input→lamp latency: 2 edges.
- Fault detection: the input pattern at edge t is sampled at t and causes fault=1 at edge t+1. At that same edge the lamps load flashing red (100), so the offending pattern is never driven.
- fault, fault_code and fault_dir update on the same edge.
- Flash counter width is $clog2(FLASH_HALF); it wraps with a phase toggle.
- Stall counter width is $clog2(MAX_DWELL+1) and saturates.
- Asserting rst mid-flash or mid-sequence forces all reset values immediately and asynchronously. The first edge after release samples normally.
- Against the controller's nominal timing (green 8, yellow 4, ring N→S→E→W), the maximum stall is 7 < MAX_DWELL, so no watchdog fault occurs.

## Structure
- Shared package traffic_pkg holds:
  - lamp encodings LAMP_RED / LAMP_YEL / LAMP_GRN / LAMP_OFF
  - fault code constants FLT_*
  - direction indices DIR_N..DIR_W
  - the controller and this block both import it.
- Sub-module lamp_seq_checker is instantiated 4×, one per direction. It contains the p/s registers, the dwell counter, and the transition and short-dwell checks, and outputs per-direction invalid/illegal/short_g/short_y flags plus a non_red flag.
- The top level holds the conflict check, watchdog, priority encoder, fault latch and flash generator.

## Test plan
- Reset, then the nominal controller sequence for 3 full rings: fault stays 0, and each lamp equals its input delayed 2 edges.
- Drive north=001 and east=001 together: after 2 edges, fault=1, code=2, dir=0. Lamps show 100 for 4 cycles, then 000 for 4, repeating, and never 001.
- north 001 for 8 cycles, then 100 directly: code=3, dir=0. Also drive south=011: code=1, dir=1.
- south green 8 cycles, then yellow for 2 cycles, then red: code=5, dir=1. North green 5 cycles, then yellow: code=4, dir=0.
- Hold north=001 with the others at 100 for 20 cycles: fault with code=6, dir=0 raised on the edge where the stall count reaches 16.
- rst pulsed during flashing: lamps return to 100 and fault/code/dir to 0 without waiting for a clock edge. The nominal sequence afterwards runs fault-free.
